// File: rtl/formula_isqrt_sum_n_fsm.sv
// Sums isqrt() over N_ARGS operands by time-sharing N_LANES external isqrt
// instances in rounds; one outstanding request per lane, lanes may skew.
module formula_isqrt_sum_n_fsm #(
    parameter int N_ARGS  = 3,
    parameter int N_LANES = 2,
    parameter int W       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arg_vld,
    output logic                     arg_rdy,
    input  logic [N_ARGS*W-1:0]      args,
    output logic                     res_vld,
    output logic [W-1:0]             res,
    output logic [N_LANES-1:0]       isqrt_x_vld,
    output logic [N_LANES*W-1:0]     isqrt_x,
    input  logic [N_LANES-1:0]       isqrt_y_vld,
    input  logic [N_LANES*W/2-1:0]   isqrt_y
);

    localparam int H  = W / 2;
    localparam int R  = (N_ARGS + N_LANES - 1) / N_LANES;
    localparam int RW = (R > 1) ? $clog2(R) : 1;

    // The argument bound keeps N_ARGS * (2**H - 1) below 2**W, so acc cannot wrap.
    if (N_ARGS < 1 || N_LANES < 1 || (W % 2) != 0 || N_ARGS > 2**H) begin : g_param_check
        $error("formula_isqrt_sum_n_fsm: illegal parameters N_ARGS=%0d N_LANES=%0d W=%0d",
               N_ARGS, N_LANES, W);
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [N_ARGS*W-1:0]    args_q;
    logic [W-1:0]           acc;
    logic [RW-1:0]          round;
    logic [N_LANES-1:0]     pending;

    logic [W-1:0]           sum;
    logic [N_LANES-1:0]     y_hit;
    logic [N_LANES-1:0]     pending_left;
    logic [N_LANES-1:0]     nx_vld;
    logic [N_LANES*W-1:0]   nx;
    logic [N_ARGS*W-1:0]    src;
    int                     issue_round;

    // Accumulate every lane finishing this cycle, and precompute the next
    // round's lane requests (from the live args when launching out of IDLE).
    always_comb begin
        sum          = acc;
        y_hit        = isqrt_y_vld & pending;
        pending_left = pending & ~y_hit;
        for (int j = 0; j < N_LANES; j++) begin
            if (y_hit[j]) begin
                sum = sum + {{(W-H){1'b0}}, isqrt_y[j*H +: H]};
            end
        end

        issue_round = (state == S_IDLE) ? 0 : int'(round) + 1;
        src         = (state == S_IDLE) ? args : args_q;
        nx_vld      = '0;
        nx          = '0;
        for (int k = 0; k < N_ARGS; k++) begin
            if (k / N_LANES == issue_round) begin
                nx_vld[k % N_LANES]        = 1'b1;
                nx[(k % N_LANES)*W +: W]   = src[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            arg_rdy     <= 1'b1;
            res_vld     <= 1'b0;
            res         <= '0;
            isqrt_x_vld <= '0;
            isqrt_x     <= '0;
            pending     <= '0;
            acc         <= '0;
            round       <= '0;
            args_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arg_vld) begin
                        args_q      <= args;
                        acc         <= '0;
                        round       <= '0;
                        arg_rdy     <= 1'b0;
                        isqrt_x_vld <= nx_vld;
                        isqrt_x     <= nx;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    pending     <= isqrt_x_vld;
                    isqrt_x_vld <= '0;
                    isqrt_x     <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    acc     <= sum;
                    pending <= pending_left;
                    if (pending_left == '0) begin
                        if (int'(round) == R - 1) begin
                            res     <= sum;
                            res_vld <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            round       <= round + 1'b1;
                            isqrt_x_vld <= nx_vld;
                            isqrt_x     <= nx;
                            state       <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    res_vld <= 1'b0;
                    arg_rdy <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_formula_isqrt_sum_n_fsm.sv
// Directed bench: a 2-lane and a 4-lane instance driven by a latency-programmable
// isqrt model, with hand-computed results and cycle offsets.
module tb_formula_isqrt_sum_n_fsm;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: defaults (3 args, 2 lanes)
    logic         a_arg_vld, a_arg_rdy, a_res_vld;
    logic [95:0]  a_args;
    logic [31:0]  a_res;
    logic [1:0]   a_x_vld, a_y_vld;
    logic [63:0]  a_x;
    logic [31:0]  a_y;

    // Instance B: 3 args, 4 lanes
    logic         b_arg_vld, b_arg_rdy, b_res_vld;
    logic [95:0]  b_args;
    logic [31:0]  b_res;
    logic [3:0]   b_x_vld, b_y_vld;
    logic [127:0] b_x;
    logic [63:0]  b_y;

    formula_isqrt_sum_n_fsm dut_a (
        .clk(clk), .rst(rst),
        .arg_vld(a_arg_vld), .arg_rdy(a_arg_rdy), .args(a_args),
        .res_vld(a_res_vld), .res(a_res),
        .isqrt_x_vld(a_x_vld), .isqrt_x(a_x),
        .isqrt_y_vld(a_y_vld), .isqrt_y(a_y)
    );

    formula_isqrt_sum_n_fsm #(.N_ARGS(3), .N_LANES(4), .W(32)) dut_b (
        .clk(clk), .rst(rst),
        .arg_vld(b_arg_vld), .arg_rdy(b_arg_rdy), .args(b_args),
        .res_vld(b_res_vld), .res(b_res),
        .isqrt_x_vld(b_x_vld), .isqrt_x(b_x),
        .isqrt_y_vld(b_y_vld), .isqrt_y(b_y)
    );

    // isqrt model: lanes 0-1 serve A, lanes 2-5 serve B, per-lane latency lat[j]
    logic [5:0]   all_x_vld;
    logic [191:0] all_x;
    logic [5:0]   m_y_vld = '0;
    logic [95:0]  m_y = '0;
    logic [1:0]   stray_vld;
    logic [31:0]  stray_y;
    int           cnt [6];
    int           lat [6];

    assign all_x_vld = {b_x_vld, a_x_vld};
    assign all_x     = {b_x, a_x};
    assign a_y_vld   = m_y_vld[1:0] | stray_vld;
    assign a_y       = m_y[31:0] | stray_y;
    assign b_y_vld   = m_y_vld[5:2];
    assign b_y       = m_y[95:32];

    function automatic logic [15:0] isqrt32(input logic [31:0] x);
        longint r = 0;
        longint c;
        for (int b = 15; b >= 0; b--) begin
            c = r | (longint'(1) << b);
            if (c * c <= longint'(x)) r = c;
        end
        return r[15:0];
    endfunction

    always @(posedge clk) begin
        for (int j = 0; j < 6; j++) begin
            m_y_vld[j] <= 1'b0;
            if (cnt[j] == 1) m_y_vld[j] <= 1'b1;
            if (cnt[j] > 0) cnt[j] <= cnt[j] - 1;
            if (all_x_vld[j]) begin
                m_y[j*16 +: 16] <= isqrt32(all_x[j*32 +: 32]);
                if (lat[j] == 1) m_y_vld[j] <= 1'b1;
                else cnt[j] <= lat[j] - 1;
            end
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand set on A (or B) at a negedge; returns in cycle T0+1.
    task automatic apply_stimulus(input bit sel_b, input logic [95:0] v, input bit hold);
        if (sel_b) begin
            b_arg_vld = 1'b1; b_args = v;
            check_output("b_rdy_at_accept", b_arg_rdy, 1);
        end else begin
            a_arg_vld = 1'b1; a_args = v;
            check_output("a_rdy_at_accept", a_arg_rdy, 1);
        end
        @(negedge clk);
        if (!hold) begin
            a_arg_vld = 1'b0;
            b_arg_vld = 1'b0;
        end
    endtask

    // Step until res_vld is seen or the budget runs out; n = cycles stepped.
    task automatic wait_res(input bit sel_b, input int budget, output int n);
        n = 0;
        while (((sel_b ? b_res_vld : a_res_vld) == 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("res_vld_seen", sel_b ? b_res_vld : a_res_vld, 1);
    endtask

    int n;
    int seen;

    initial begin
        rst = 1'b1;
        a_arg_vld = 1'b0; a_args = '0;
        b_arg_vld = 1'b0; b_args = '0;
        stray_vld = '0; stray_y = '0;
        for (int j = 0; j < 6; j++) lat[j] = 4;
        repeat (3) @(negedge clk);

        check_output("rst_arg_rdy", a_arg_rdy, 1);
        check_output("rst_res_vld", a_res_vld, 0);
        check_output("rst_res", a_res, 0);
        check_output("rst_x_vld", a_x_vld, 0);
        check_output("rst_x", a_x, 0);
        check_output("rst_b_x_vld", b_x_vld, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: {9,16,25}, L=4
        $display("[TB] basic two-round sum");
        apply_stimulus(0, {32'd25, 32'd16, 32'd9}, 0);
        check_output("t1_issue0_vld", a_x_vld, 2'b11);
        check_output("t1_issue0_x", a_x, {32'd16, 32'd9});
        check_output("t1_busy_rdy", a_arg_rdy, 0);
        repeat (4) @(negedge clk);
        check_output("t1_wait_x_vld", a_x_vld, 0);
        @(negedge clk);
        check_output("t1_issue1_vld", a_x_vld, 2'b01);
        check_output("t1_issue1_x", a_x, {32'd0, 32'd25});
        wait_res(0, 30, n);
        check_output("t1_latency", n, 5);
        check_output("t1_res", a_res, 12);
        check_output("t1_rdy_during_res", a_arg_rdy, 0);
        @(negedge clk);
        check_output("t1_res_vld_drop", a_res_vld, 0);
        check_output("t1_res_hold", a_res, 12);
        check_output("t1_rdy_back", a_arg_rdy, 1);

        // 2: max operands
        $display("[TB] max operands");
        apply_stimulus(0, {3{32'hFFFF_FFFF}}, 0);
        wait_res(0, 30, n);
        check_output("t2_latency", n, 10);
        check_output("t2_res", a_res, 32'h2FFFD);
        @(negedge clk);

        // 3: skewed lanes, lane 0 L=2, lane 1 L=7
        $display("[TB] skewed lanes");
        lat[0] = 2; lat[1] = 7;
        apply_stimulus(0, {32'd49, 32'd4, 32'd100}, 0);
        repeat (7) @(negedge clk);
        check_output("t3_no_early_issue", a_x_vld, 0);
        @(negedge clk);
        check_output("t3_issue1_vld", a_x_vld, 2'b01);
        check_output("t3_issue1_x", a_x, {32'd0, 32'd49});
        wait_res(0, 30, n);
        check_output("t3_latency", n, 3);
        check_output("t3_res", a_res, 19);
        @(negedge clk);
        lat[0] = 4; lat[1] = 4;

        // 4: arg_vld held high with new operands while busy
        $display("[TB] arg_vld held while busy");
        apply_stimulus(0, {32'd25, 32'd16, 32'd9}, 1);
        a_args = {32'd1, 32'd1, 32'd1};
        check_output("t4_busy_rdy", a_arg_rdy, 0);
        wait_res(0, 30, n);
        check_output("t4_latency", n, 10);
        check_output("t4_res_first", a_res, 12);
        @(negedge clk);
        check_output("t4_idle_rdy", a_arg_rdy, 1);
        @(negedge clk);
        a_arg_vld = 1'b0;
        check_output("t4_second_issue", a_x_vld, 2'b11);
        check_output("t4_second_x", a_x, {32'd1, 32'd1});
        wait_res(0, 30, n);
        check_output("t4_res_second", a_res, 3);
        @(negedge clk);

        // 5: reset in WAIT of round 0, then stray responses
        $display("[TB] reset mid-operation");
        apply_stimulus(0, {32'd25, 32'd16, 32'd9}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("t5_rdy", a_arg_rdy, 1);
        check_output("t5_res", a_res, 0);
        check_output("t5_x_vld", a_x_vld, 0);
        stray_vld = 2'b11; stray_y = {16'd7, 16'd7};
        @(negedge clk);
        stray_vld = 2'b00; stray_y = '0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_res_vld) seen++;
            @(negedge clk);
        end
        check_output("t5_no_res_vld", seen, 0);
        check_output("t5_res_still_0", a_res, 0);
        apply_stimulus(0, {32'd4, 32'd1, 32'd0}, 0);
        wait_res(0, 30, n);
        check_output("t5_res_fresh", a_res, 3);
        @(negedge clk);

        // 6: four lanes, single round, L=3
        $display("[TB] wide lane pool");
        for (int j = 2; j < 6; j++) lat[j] = 3;
        apply_stimulus(1, {32'd121, 32'd81, 32'd64}, 0);
        check_output("t6_issue_vld", b_x_vld, 4'b0111);
        check_output("t6_issue_x", b_x, {32'd0, 32'd121, 32'd81, 32'd64});
        wait_res(1, 30, n);
        check_output("t6_latency", n, 4);
        check_output("t6_res", b_res, 28);
        check_output("t6_lane3_idle", b_x_vld[3], 0);
        @(negedge clk);
        check_output("t6_rdy_back", b_arg_rdy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
